// File: rtl/ac_compressor_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ac_compressor_sequencer
// Description : Sequences the air-conditioner power stage (fan, compressor,
//               reversing valve) from the power switch and the 2-bit mode.
//               Guarantees fan lead before compressor start, fan tail after
//               compressor stop, a minimum compressor off-time (guard), and
//               valve changes only while the compressor is off.
//
//               Mode: 00 fan-only, 01 dehumidify, 10 cool, 11 heat.
//
//               Optional feature macro: AC_DRY_CYCLE_EN
//                 defined   - mode 01 duty-cycles the compressor through
//                             RUN / DRY_REST using DRY_ON / DRY_OFF ticks.
//                 undefined - mode 01 runs like cool with the fan on low;
//                             the DRY_REST state and its timer are absent.
//
// Ports       : clk          system clock
//               rst          asynchronous active-high reset
//               power        unit on/off level (asynchronous, synchronized)
//               mode[1:0]    operating mode (asynchronous, synchronized)
//               fan_en       fan running
//               fan_hi       fan high speed (low in dehumidify)
//               comp_en      compressor contactor
//               valve_heat   reversing valve, 1 = heat
//               guard_active compressor off-time guard running
//               state[2:0]   current FSM state for debug/LED
//
// Revision    : 1.0 - initial release
// ============================================================================
module ac_compressor_sequencer #(
    parameter int TICK_DIV   = 50000000,
    parameter int FAN_LEAD   = 3,
    parameter int FAN_TAIL   = 5,
    parameter int COMP_GUARD = 180,
    parameter int DRY_ON     = 10,
    parameter int DRY_OFF    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] mode,
    output logic       fan_en,
    output logic       fan_hi,
    output logic       comp_en,
    output logic       valve_heat,
    output logic       guard_active,
    output logic [2:0] state
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_FAN_ONLY = 3'd1;
    localparam logic [2:0] c_LEAD     = 3'd2;
    localparam logic [2:0] c_RUN      = 3'd3;
`ifdef AC_DRY_CYCLE_EN
    localparam logic [2:0] c_DRY_REST = 3'd4;
`endif
    localparam logic [2:0] c_TAIL     = 3'd5;

    // ------------------------------------------------------------------
    // Counter widths: each timer is just wide enough to hold its load value
    // ------------------------------------------------------------------
    localparam int c_PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)       : 1;
    localparam int c_LW = (FAN_LEAD   > 0) ? $clog2(FAN_LEAD + 1)   : 1;
    localparam int c_TW = (FAN_TAIL   > 0) ? $clog2(FAN_TAIL + 1)   : 1;
    localparam int c_GW = (COMP_GUARD > 0) ? $clog2(COMP_GUARD + 1) : 1;

    localparam logic [c_PW-1:0] c_PRE_MAX  = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRE_ONE  = c_PW'(1);
    localparam logic [c_LW-1:0] c_LEAD_LD  = c_LW'(FAN_LEAD);
    localparam logic [c_LW-1:0] c_LEAD_ONE = c_LW'(1);
    localparam logic [c_TW-1:0] c_TAIL_LD  = c_TW'(FAN_TAIL);
    localparam logic [c_TW-1:0] c_TAIL_ONE = c_TW'(1);
    localparam logic [c_GW-1:0] c_GRD_LD   = c_GW'(COMP_GUARD);
    localparam logic [c_GW-1:0] c_GRD_ONE  = c_GW'(1);

`ifdef AC_DRY_CYCLE_EN
    localparam int c_DMAX = (DRY_ON > DRY_OFF) ? DRY_ON : DRY_OFF;
    localparam int c_DW   = (c_DMAX > 0) ? $clog2(c_DMAX + 1) : 1;
    localparam logic [c_DW-1:0] c_DRY_ON_LD  = c_DW'(DRY_ON);
    localparam logic [c_DW-1:0] c_DRY_OFF_LD = c_DW'(DRY_OFF);
    localparam logic [c_DW-1:0] c_DRY_ONE    = c_DW'(1);
`else
    logic w_unused_dry;
    assign w_unused_dry = ((DRY_ON + DRY_OFF) != 0);
`endif

    // ------------------------------------------------------------------
    // Input synchronizers. The mode bits come from a registered selector
    // and change rarely, so per-bit synchronization is adequate.
    // ------------------------------------------------------------------
    logic       r_power_m, r_power_s;
    logic [1:0] r_mode_m,  r_mode_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_power_m <= 1'b0;
            r_power_s <= 1'b0;
            r_mode_m  <= 2'b00;
            r_mode_s  <= 2'b00;
        end else begin
            r_power_m <= power;
            r_power_s <= r_power_m;
            r_mode_m  <= mode;
            r_mode_s  <= r_mode_m;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: one-clk tick every TICK_DIV cycles
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_pre;
    logic            w_tick;

    assign w_tick = (r_pre == c_PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_pre <= '0;
        else if (w_tick) r_pre <= '0;
        else             r_pre <= r_pre + c_PRE_ONE;
    end

    // ------------------------------------------------------------------
    // Mode decode
    // ------------------------------------------------------------------
    logic w_need, w_req_valve, w_dry_mode;

    assign w_need      = (r_mode_s != 2'b00);
    assign w_req_valve = (r_mode_s == 2'b11);
    assign w_dry_mode  = (r_mode_s == 2'b01);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [c_LW-1:0] r_lead;
    logic [c_TW-1:0] r_tail;
    logic [c_GW-1:0] r_guard;
    logic            r_fan_en, r_fan_hi, r_comp_en, r_valve_heat, r_guard_active;
`ifdef AC_DRY_CYCLE_EN
    logic [c_DW-1:0] r_dry;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [2:0] w_state_nx;
    logic       w_lead_ld, w_tail_ld;
`ifdef AC_DRY_CYCLE_EN
    logic       w_dry_ld_on, w_dry_ld_off;
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_lead_ld    = 1'b0;
        w_tail_ld    = 1'b0;
`ifdef AC_DRY_CYCLE_EN
        w_dry_ld_on  = 1'b0;
        w_dry_ld_off = 1'b0;
`endif
        case (r_state)
            c_IDLE: begin
                if (r_power_s) begin
                    if (w_need) begin
                        w_state_nx = c_LEAD;
                        w_lead_ld  = 1'b1;
                    end else begin
                        w_state_nx = c_FAN_ONLY;
                    end
                end
            end
            c_FAN_ONLY: begin
                if (!r_power_s) begin
                    w_state_nx = c_IDLE;
                end else if (w_need) begin
                    w_state_nx = c_LEAD;
                    w_lead_ld  = 1'b1;
                end
            end
            c_LEAD: begin
                // Compressor has not run yet, so power-off skips the tail.
                if (!r_power_s) begin
                    w_state_nx = c_IDLE;
                end else if (!w_need) begin
                    w_state_nx = c_FAN_ONLY;
                end else if (w_req_valve != r_valve_heat) begin
                    // Re-entry: restart the lead and move the valve.
                    w_lead_ld  = 1'b1;
                end else if ((r_lead == '0) && (r_guard == '0)) begin
                    w_state_nx = c_RUN;
`ifdef AC_DRY_CYCLE_EN
                    w_dry_ld_on = 1'b1;
`endif
                end
            end
            c_RUN: begin
                if (!r_power_s || !w_need || (w_req_valve != r_valve_heat)) begin
                    w_state_nx = c_TAIL;
                    w_tail_ld  = 1'b1;
`ifdef AC_DRY_CYCLE_EN
                end else if (w_dry_mode && (r_dry == '0)) begin
                    w_state_nx   = c_DRY_REST;
                    w_dry_ld_off = 1'b1;
                end else if (!w_dry_mode) begin
                    // Hold the on-timer full so a later switch into mode 01
                    // starts a fresh DRY_ON window.
                    w_dry_ld_on = 1'b1;
`endif
                end
            end
`ifdef AC_DRY_CYCLE_EN
            c_DRY_REST: begin
                if (!r_power_s || !w_dry_mode) begin
                    w_state_nx = c_TAIL;
                    w_tail_ld  = 1'b1;
                end else if ((r_dry == '0) && (r_guard == '0)) begin
                    w_state_nx  = c_RUN;
                    w_dry_ld_on = 1'b1;
                end
            end
`endif
            c_TAIL: begin
                if (r_tail == '0) begin
                    if (!r_power_s) begin
                        w_state_nx = c_IDLE;
                    end else if (w_need) begin
                        w_state_nx = c_LEAD;
                        w_lead_ld  = 1'b1;
                    end else begin
                        w_state_nx = c_FAN_ONLY;
                    end
                end
            end
            default: begin
                w_state_nx = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / guard next values, decoded from the next state so that the
    // registered outputs always agree with the registered state.
    // ------------------------------------------------------------------
    logic            w_fan_en_nx, w_fan_hi_nx, w_comp_en_nx, w_valve_nx;
    logic            w_comp_stop;
    logic [c_GW-1:0] w_guard_nx;

    always_comb begin
        w_fan_en_nx  = (w_state_nx != c_IDLE);
        w_comp_en_nx = (w_state_nx == c_RUN);
        w_fan_hi_nx  = 1'b0;
        case (w_state_nx)
            c_FAN_ONLY:            w_fan_hi_nx = 1'b1;
            c_LEAD, c_RUN, c_TAIL: w_fan_hi_nx = ~w_dry_mode;
            default:               w_fan_hi_nx = 1'b0;
        endcase

        // The valve only moves on LEAD entry, when the compressor is off.
        if (w_state_nx == c_IDLE) w_valve_nx = 1'b0;
        else if (w_lead_ld)       w_valve_nx = w_req_valve;
        else                      w_valve_nx = r_valve_heat;

        w_comp_stop = (r_state == c_RUN) && (w_state_nx != c_RUN);
        if (w_comp_stop)                   w_guard_nx = c_GRD_LD;
        else if (w_tick && r_guard != '0)  w_guard_nx = r_guard - c_GRD_ONE;
        else                               w_guard_nx = r_guard;
    end

    // ------------------------------------------------------------------
    // State, timers and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_lead         <= '0;
            r_tail         <= '0;
            r_guard        <= '0;
            r_fan_en       <= 1'b0;
            r_fan_hi       <= 1'b0;
            r_comp_en      <= 1'b0;
            r_valve_heat   <= 1'b0;
            r_guard_active <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_guard        <= w_guard_nx;
            r_fan_en       <= w_fan_en_nx;
            r_fan_hi       <= w_fan_hi_nx;
            r_comp_en      <= w_comp_en_nx;
            r_valve_heat   <= w_valve_nx;
            r_guard_active <= (w_guard_nx != '0);

            if (w_lead_ld)                  r_lead <= c_LEAD_LD;
            else if (w_tick && r_lead != '0) r_lead <= r_lead - c_LEAD_ONE;

            if (w_tail_ld)                  r_tail <= c_TAIL_LD;
            else if (w_tick && r_tail != '0) r_tail <= r_tail - c_TAIL_ONE;
        end
    end

`ifdef AC_DRY_CYCLE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_dry <= '0;
        else if (w_dry_ld_on)           r_dry <= c_DRY_ON_LD;
        else if (w_dry_ld_off)          r_dry <= c_DRY_OFF_LD;
        else if (w_tick && r_dry != '0) r_dry <= r_dry - c_DRY_ONE;
    end
`endif

    assign fan_en       = r_fan_en;
    assign fan_hi       = r_fan_hi;
    assign comp_en      = r_comp_en;
    assign valve_heat   = r_valve_heat;
    assign guard_active = r_guard_active;
    assign state        = r_state;

endmodule
`default_nettype wire
